// File: rtl/arbiter_rr_lock_n.sv
// arbiter_rr_lock_n
//   Flat N-way round-robin arbiter with a registered output stage and optional
//   packet locking. Merges N valid/ready streams onto one tagged output stream.
//
// Ports
//   clk                 rising-edge clock for all state
//   reset               asynchronous, active-high reset
//   in_valid[N]         per-channel request
//   in_data[N]          per-channel payload (DWIDTH bits)
//   in_last[N]          last beat of a packet (locks only when LOCK_ON_LAST=1)
//   in_ready[N]         per-channel accept, at most one high per cycle
//   out_valid           registered output valid
//   out_data            registered payload
//   out_last            registered in_last of the transferred beat
//   out_id              index of the channel that supplied out_data
//   out_ready           downstream accept
module arbiter_rr_lock_n #(
  parameter int DWIDTH       = 16,
  parameter int N            = 4,
  parameter int LOCK_ON_LAST = 1,
  parameter int IDW          = (N > 1) ? $clog2(N) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid [N-1:0],
  input  logic [DWIDTH-1:0] in_data  [N-1:0],
  input  logic              in_last  [N-1:0],
  output logic              in_ready [N-1:0],
  output logic              out_valid,
  output logic [DWIDTH-1:0] out_data,
  output logic              out_last,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);

  localparam bit LOCK_EN = (LOCK_ON_LAST != 0);

  // Architectural state
  logic [IDW-1:0]    ptr_reg;
  logic              locked_reg;
  logic [IDW-1:0]    lock_id_reg;
  logic              out_valid_reg;
  logic [DWIDTH-1:0] out_data_reg;
  logic              out_last_reg;
  logic [IDW-1:0]    out_id_reg;

  // Arbitration signals
  logic              load_en;
  logic [N-1:0]      eligible;
  logic [N-1:0]      upper_mask;
  logic [N-1:0]      eligible_upper;
  logic              grant_found;
  logic [IDW-1:0]    grant_id;
  logic [DWIDTH-1:0] grant_data;
  logic              grant_last;
  logic              xfer;
  logic [IDW-1:0]    ptr_next;

  // Index of the lowest set bit of v (0 when v is empty; callers gate on |v).
  function automatic logic [IDW-1:0] lowest_idx(input logic [N-1:0] v);
    logic [IDW-1:0] idx;
    idx = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (v[k]) idx = IDW'(k);
    end
    return idx;
  endfunction

  // The output register can take a new beat when empty or being drained.
  assign load_en = !out_valid_reg || out_ready;

  generate
    for (genvar gi = 0; gi < N; gi++) begin : g_chan
      // While a packet is in flight only its owner may compete.
      assign eligible[gi]   = in_valid[gi] && (!locked_reg || (lock_id_reg == IDW'(gi)));
      // Channels at or above the pointer are searched first.
      assign upper_mask[gi] = (IDW'(gi) >= ptr_reg);
      assign in_ready[gi]   = !reset && load_en && grant_found && (grant_id == IDW'(gi));
    end
  endgenerate

  // Rotating priority: first eligible at or after ptr, otherwise wrap to the
  // lowest eligible index below ptr.
  assign eligible_upper = eligible & upper_mask;
  assign grant_found    = |eligible;
  assign grant_id       = (|eligible_upper) ? lowest_idx(eligible_upper) : lowest_idx(eligible);

  always_comb begin
    grant_data = '0;
    grant_last = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (grant_id == IDW'(k)) begin
        grant_data = in_data[k];
        grant_last = in_last[k];
      end
    end
  end

  // Eligibility already implies in_valid, so a grant with load_en is a transfer.
  assign xfer     = grant_found && load_en;
  assign ptr_next = (grant_id == IDW'(N - 1)) ? '0 : grant_id + IDW'(1);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg       <= '0;
      locked_reg    <= 1'b0;
      lock_id_reg   <= '0;
      out_valid_reg <= 1'b0;
      out_data_reg  <= '0;
      out_last_reg  <= 1'b0;
      out_id_reg    <= '0;
    end else if (load_en) begin
      // With nothing eligible the output bubbles; payload/id/last keep their values.
      out_valid_reg <= xfer;
      if (xfer) begin
        out_data_reg <= grant_data;
        out_last_reg <= grant_last;
        out_id_reg   <= grant_id;
        if (LOCK_EN && !grant_last) begin
          // Mid-packet: pin the grant, leave the pointer where it is.
          locked_reg  <= 1'b1;
          lock_id_reg <= grant_id;
        end else begin
          locked_reg <= 1'b0;
          ptr_reg    <= ptr_next;
        end
      end
    end
  end

  assign out_valid = out_valid_reg;
  assign out_data  = out_data_reg;
  assign out_last  = out_last_reg;
  assign out_id    = out_id_reg;

endmodule

// File: tb/tb_arbiter_rr_lock_n.sv
// Directed bench for arbiter_rr_lock_n: a locking N=4 instance (a_*), a
// non-locking N=4 instance (b_*) and an N=1 instance (c_*).
module tb_arbiter_rr_lock_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        a_valid [3:0];
  logic [15:0] a_data  [3:0];
  logic        a_last  [3:0];
  logic        a_ready [3:0];
  logic        a_out_valid;
  logic [15:0] a_out_data;
  logic        a_out_last;
  logic [1:0]  a_out_id;
  logic        a_out_ready;

  logic        b_valid [3:0];
  logic [15:0] b_data  [3:0];
  logic        b_last  [3:0];
  logic        b_ready [3:0];
  logic        b_out_valid;
  logic [15:0] b_out_data;
  logic        b_out_last;
  logic [1:0]  b_out_id;
  logic        b_out_ready;

  logic        c_valid [0:0];
  logic [15:0] c_data  [0:0];
  logic        c_last  [0:0];
  logic        c_ready [0:0];
  logic        c_out_valid;
  logic [15:0] c_out_data;
  logic        c_out_last;
  logic [0:0]  c_out_id;
  logic        c_out_ready;

  int checks = 0;
  int errors = 0;
  int a_cnt [4];

  arbiter_rr_lock_n #(.DWIDTH(16), .N(4), .LOCK_ON_LAST(1)) dut_a (
    .clk(clk), .reset(reset),
    .in_valid(a_valid), .in_data(a_data), .in_last(a_last), .in_ready(a_ready),
    .out_valid(a_out_valid), .out_data(a_out_data), .out_last(a_out_last),
    .out_id(a_out_id), .out_ready(a_out_ready)
  );

  arbiter_rr_lock_n #(.DWIDTH(16), .N(4), .LOCK_ON_LAST(0)) dut_b (
    .clk(clk), .reset(reset),
    .in_valid(b_valid), .in_data(b_data), .in_last(b_last), .in_ready(b_ready),
    .out_valid(b_out_valid), .out_data(b_out_data), .out_last(b_out_last),
    .out_id(b_out_id), .out_ready(b_out_ready)
  );

  arbiter_rr_lock_n #(.DWIDTH(16), .N(1), .LOCK_ON_LAST(1)) dut_c (
    .clk(clk), .reset(reset),
    .in_valid(c_valid), .in_data(c_data), .in_last(c_last), .in_ready(c_ready),
    .out_valid(c_out_valid), .out_data(c_out_data), .out_last(c_out_last),
    .out_id(c_out_id), .out_ready(c_out_ready)
  );

  // One line per output handshake; per-channel beat counts for instance a.
  always @(posedge clk) begin
    if (a_out_valid && a_out_ready) begin
      a_cnt[a_out_id] <= a_cnt[a_out_id] + 1;
      $display("a beat id=%0d data=%h last=%0d", a_out_id, a_out_data, a_out_last);
    end
    if (b_out_valid && b_out_ready)
      $display("b beat id=%0d data=%h last=%0d", b_out_id, b_out_data, b_out_last);
    if (c_out_valid && c_out_ready)
      $display("c beat id=%0d data=%h last=%0d", c_out_id, c_out_data, c_out_last);
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_a(input int ch, input logic v, input logic [15:0] d, input logic l);
    a_valid[ch] = v; a_data[ch] = d; a_last[ch] = l;
  endtask

  task automatic set_b(input int ch, input logic v, input logic [15:0] d, input logic l);
    b_valid[ch] = v; b_data[ch] = d; b_last[ch] = l;
  endtask

  task automatic chk_a_ready(input string tag, input logic [3:0] exp);
    chk(tag, 32'({a_ready[3], a_ready[2], a_ready[1], a_ready[0]}), 32'(exp));
  endtask

  task automatic chk_b_ready(input string tag, input logic [3:0] exp);
    chk(tag, 32'({b_ready[3], b_ready[2], b_ready[1], b_ready[0]}), 32'(exp));
  endtask

  task automatic chk_a_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [15:0] d, input logic l);
    chk({tag, "_valid"}, 32'(a_out_valid), 32'(v));
    chk({tag, "_id"},    32'(a_out_id),    32'(id));
    chk({tag, "_data"},  32'(a_out_data),  32'(d));
    chk({tag, "_last"},  32'(a_out_last),  32'(l));
  endtask

  task automatic chk_b_out(input string tag, input logic v, input logic [1:0] id,
                           input logic [15:0] d, input logic l);
    chk({tag, "_valid"}, 32'(b_out_valid), 32'(v));
    chk({tag, "_id"},    32'(b_out_id),    32'(id));
    chk({tag, "_data"},  32'(b_out_data),  32'(d));
    chk({tag, "_last"},  32'(b_out_last),  32'(l));
  endtask

  initial begin
    reset = 1'b1;
    a_out_ready = 1'b1;
    b_out_ready = 1'b1;
    c_out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      set_a(i, 1'b1, 16'h1000 + 16'(i), 1'b1);
      set_b(i, 1'b0, 16'h0000, 1'b0);
    end
    c_valid[0] = 1'b0; c_data[0] = 16'h0000; c_last[0] = 1'b0;

    // Reset held with every channel requesting
    repeat (2) @(posedge clk);
    #1;
    chk_a_ready("rst_ready", 4'b0000);
    chk_a_out("rst_out", 1'b0, 2'd0, 16'h0000, 1'b0);
    chk("rst_b_valid", 32'(b_out_valid), 32'd0);

    // Fairness: all valid, every beat last
    reset = 1'b0;
    #1;
    chk_a_ready("rel_ready", 4'b0001);
    for (int k = 0; k < 6; k++) begin
      tick();
      chk_a_out($sformatf("rr%0d", k), 1'b1, 2'(k % 4), 16'h1000 + 16'(k % 4), 1'b1);
    end
    for (int i = 0; i < 4; i++) a_valid[i] = 1'b0;
    tick();
    chk_a_out("idle", 1'b0, 2'd1, 16'h1001, 1'b1);

    // Single requester on channel 2, then the search resumes at 3
    set_a(2, 1'b1, 16'hBEEF, 1'b1);
    #1;
    chk_a_ready("beef_rdy", 4'b0100);
    tick();
    chk_a_out("beef", 1'b1, 2'd2, 16'hBEEF, 1'b1);
    set_a(0, 1'b1, 16'h1000, 1'b1);
    set_a(3, 1'b1, 16'h3333, 1'b1);
    #1;
    chk_a_ready("ptr3_rdy", 4'b1000);
    tick();
    chk_a_out("ptr3", 1'b1, 2'd3, 16'h3333, 1'b1);
    a_valid[2] = 1'b0;
    a_valid[3] = 1'b0;
    #1;
    chk_a_ready("ptr0_rdy", 4'b0001);
    tick();
    chk_a_out("ptr0", 1'b1, 2'd0, 16'h1000, 1'b1);

    // Locked 3-beat packet on channel 1 with a 2-cycle gap; 0 and 3 keep requesting
    set_a(0, 1'b1, 16'hA000, 1'b1);
    set_a(1, 1'b1, 16'hB001, 1'b0);
    set_a(3, 1'b1, 16'hD000, 1'b1);
    #1;
    chk_a_ready("lk0_rdy", 4'b0010);
    tick();
    chk_a_out("lk1", 1'b1, 2'd1, 16'hB001, 1'b0);
    set_a(1, 1'b1, 16'hB002, 1'b0);
    #1;
    chk_a_ready("lk1_rdy", 4'b0010);
    tick();
    chk_a_out("lk2", 1'b1, 2'd1, 16'hB002, 1'b0);
    a_valid[1] = 1'b0;
    #1;
    chk_a_ready("lk_gap_rdy", 4'b0000);
    tick();
    chk_a_out("bub1", 1'b0, 2'd1, 16'hB002, 1'b0);
    chk_a_ready("bub1_rdy", 4'b0000);
    tick();
    chk_a_out("bub2", 1'b0, 2'd1, 16'hB002, 1'b0);
    set_a(1, 1'b1, 16'hB003, 1'b1);
    #1;
    chk_a_ready("lk3_rdy", 4'b0010);
    tick();
    chk_a_out("lk3", 1'b1, 2'd1, 16'hB003, 1'b1);
    a_valid[1] = 1'b0;
    #1;
    chk_a_ready("unlk_rdy", 4'b1000);
    tick();
    chk_a_out("unlk", 1'b1, 2'd3, 16'hD000, 1'b1);
    a_valid[0] = 1'b0;
    a_valid[3] = 1'b0;
    tick();
    chk("lk_drain", 32'(a_out_valid), 32'd0);

    // Same traffic on the non-locking instance interleaves
    set_b(0, 1'b1, 16'h0A00, 1'b1);
    tick();
    chk_b_out("nl0", 1'b1, 2'd0, 16'h0A00, 1'b1);
    set_b(0, 1'b1, 16'hA000, 1'b1);
    set_b(1, 1'b1, 16'hB001, 1'b0);
    set_b(3, 1'b1, 16'hD000, 1'b1);
    #1;
    chk_b_ready("nl0_rdy", 4'b0010);
    tick();
    chk_b_out("nl1", 1'b1, 2'd1, 16'hB001, 1'b0);
    set_b(1, 1'b1, 16'hB002, 1'b0);
    #1;
    chk_b_ready("nl1_rdy", 4'b1000);
    tick();
    chk_b_out("nl2", 1'b1, 2'd3, 16'hD000, 1'b1);
    b_valid[3] = 1'b0;
    #1;
    chk_b_ready("nl2_rdy", 4'b0001);
    tick();
    chk_b_out("nl3", 1'b1, 2'd0, 16'hA000, 1'b1);
    b_valid[0] = 1'b0;
    #1;
    chk_b_ready("nl3_rdy", 4'b0010);
    tick();
    chk_b_out("nl4", 1'b1, 2'd1, 16'hB002, 1'b0);
    set_b(1, 1'b1, 16'hB003, 1'b1);
    tick();
    chk_b_out("nl5", 1'b1, 2'd1, 16'hB003, 1'b1);
    b_valid[1] = 1'b0;

    // Output stall for 5 cycles, then release
    set_a(2, 1'b1, 16'h0123, 1'b1);
    tick();
    chk_a_out("st_ld", 1'b1, 2'd2, 16'h0123, 1'b1);
    a_out_ready = 1'b0;
    set_a(2, 1'b1, 16'h0456, 1'b1);
    set_a(0, 1'b1, 16'h0789, 1'b1);
    #1;
    chk_a_ready("st_rdy", 4'b0000);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk_a_out($sformatf("stall%0d", k), 1'b1, 2'd2, 16'h0123, 1'b1);
      chk_a_ready($sformatf("stall%0d_rdy", k), 4'b0000);
    end
    a_out_ready = 1'b1;
    #1;
    chk_a_ready("unstall_rdy", 4'b0001);
    tick();
    chk_a_out("us1", 1'b1, 2'd0, 16'h0789, 1'b1);
    a_valid[0] = 1'b0;
    #1;
    chk_a_ready("us1_rdy", 4'b0100);
    tick();
    chk_a_out("us2", 1'b1, 2'd2, 16'h0456, 1'b1);
    a_valid[2] = 1'b0;
    tick();
    chk("us_drain", 32'(a_out_valid), 32'd0);
    chk("cnt_ch0", 32'(a_cnt[0]), 32'd4);
    chk("cnt_ch1", 32'(a_cnt[1]), 32'd5);
    chk("cnt_ch2", 32'(a_cnt[2]), 32'd4);
    chk("cnt_ch3", 32'(a_cnt[3]), 32'd3);

    // Reset while locked on channel 2 mid-packet
    set_a(2, 1'b1, 16'h2001, 1'b0);
    #1;
    chk_a_ready("rl_rdy", 4'b0100);
    tick();
    chk_a_out("rl1", 1'b1, 2'd2, 16'h2001, 1'b0);
    set_a(0, 1'b1, 16'h0001, 1'b1);
    set_a(2, 1'b1, 16'h2002, 1'b0);
    #1;
    chk_a_ready("rl_excl_rdy", 4'b0100);
    tick();
    chk_a_out("rl2", 1'b1, 2'd2, 16'h2002, 1'b0);
    reset = 1'b1;
    #1;
    chk_a_out("rl_rst", 1'b0, 2'd0, 16'h0000, 1'b0);
    chk_a_ready("rl_rst_rdy", 4'b0000);
    tick();
    reset = 1'b0;
    #1;
    chk_a_ready("post_rst_rdy", 4'b0001);
    tick();
    chk_a_out("post_rst", 1'b1, 2'd0, 16'h0001, 1'b1);
    a_valid[0] = 1'b0;
    #1;
    chk_a_ready("post_rst2_rdy", 4'b0100);
    a_valid[2] = 1'b0;

    // Single-channel instance
    c_valid[0] = 1'b1; c_data[0] = 16'h5555; c_last[0] = 1'b0;
    #1;
    chk("n1_rdy0", 32'(c_ready[0]), 32'd1);
    tick();
    chk("n1_valid0", 32'(c_out_valid), 32'd1);
    chk("n1_id0",    32'(c_out_id),    32'd0);
    chk("n1_data0",  32'(c_out_data),  32'h5555);
    c_data[0] = 16'h6666; c_last[0] = 1'b1;
    #1;
    chk("n1_rdy1", 32'(c_ready[0]), 32'd1);
    tick();
    chk("n1_data1", 32'(c_out_data), 32'h6666);
    chk("n1_last1", 32'(c_out_last), 32'd1);
    chk("n1_id1",   32'(c_out_id),   32'd0);
    c_valid[0] = 1'b0;
    tick();
    chk("n1_idle", 32'(c_out_valid), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
